// File: rtl/clock_ctrl_if.sv
// Bus between the mode/alarm controller and its surroundings: buttons, tick and
// counter value in; counter control, display and alarm status out.
interface clock_ctrl_if;
  logic        i_tick;
  logic        i_btn_mode;
  logic        i_btn_inc;
  logic        i_btn_alarm;
  logic [15:0] i_cur_time;
  logic        o_cnt_en;
  logic        o_ld;
  logic [15:0] o_ld_time;
  logic [15:0] o_disp_time;
  logic [3:0]  o_blank;
  logic        o_alarm_armed;
  logic        o_ring;

  modport slave (
    input  i_tick, i_btn_mode, i_btn_inc, i_btn_alarm, i_cur_time,
    output o_cnt_en, o_ld, o_ld_time, o_disp_time, o_blank, o_alarm_armed, o_ring
  );

  modport master (
    output i_tick, i_btn_mode, i_btn_inc, i_btn_alarm, i_cur_time,
    input  o_cnt_en, o_ld, o_ld_time, o_disp_time, o_blank, o_alarm_armed, o_ring
  );
endinterface

// File: rtl/clock_ctrl.sv
// Mode/alarm controller for a 12-hour BCD clock: button-driven time and alarm
// editing, counter load strobe, display select with per-digit blink, alarm ring.
module clock_ctrl #(
  parameter int BLINK_CYCLES = 4,
  parameter int RING_TICKS   = 60
) (
  input logic         clk,
  input logic         rst_n,
  clock_ctrl_if.slave bus
);

  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int RW = $clog2(RING_TICKS + 1);

  typedef enum logic [2:0] {RUN, SET_TH, SET_TM, SET_AH, SET_AM, RING} state_t;

  state_t        r_state, w_stateNext;
  logic [15:0]   r_edit, w_editNext;
  logic [15:0]   r_alarm, w_alarmNext;
  logic [15:0]   r_ldTime, w_ldTimeNext;
  logic          r_armed, w_armedNext;
  logic          r_ld, w_ldNext;
  logic          r_matchQ;
  logic          r_phase;
  logic [BW-1:0] r_blinkCnt;
  logic [RW-1:0] r_ringCnt, w_ringCntNext;
  logic          w_match, w_inSet, w_nextInSet, w_enterSet, w_hourState, w_runLike;

  function automatic logic [7:0] incHour(input logic [7:0] h);
    if (h == 8'h12)           return 8'h01;
    else if (h[3:0] == 4'h9)  return {h[7:4] + 4'h1, 4'h0};
    else                      return {h[7:4], h[3:0] + 4'h1};
  endfunction

  // Minutes wrap on their own; hours are never touched from a minute edit.
  function automatic logic [7:0] incMin(input logic [7:0] m);
    if (m == 8'h59)           return 8'h00;
    else if (m[3:0] == 4'h9)  return {m[7:4] + 4'h1, 4'h0};
    else                      return {m[7:4], m[3:0] + 4'h1};
  endfunction

  assign w_match     = (bus.i_cur_time == r_alarm);
  assign w_inSet     = (r_state == SET_TH) || (r_state == SET_TM) ||
                       (r_state == SET_AH) || (r_state == SET_AM);
  assign w_nextInSet = (w_stateNext == SET_TH) || (w_stateNext == SET_TM) ||
                       (w_stateNext == SET_AH) || (w_stateNext == SET_AM);
  assign w_enterSet  = w_nextInSet && (w_stateNext != r_state);
  assign w_hourState = (r_state == SET_TH) || (r_state == SET_AH);
  assign w_runLike   = (r_state == RUN) || (r_state == RING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext   = r_state;
    w_editNext    = r_edit;
    w_alarmNext   = r_alarm;
    w_ldTimeNext  = r_ldTime;
    w_armedNext   = r_armed;
    w_ldNext      = 1'b0;
    w_ringCntNext = r_ringCnt;
    case (r_state)
      RUN: begin
        if (r_armed && w_match && !r_matchQ) begin
          w_stateNext   = RING;
          w_ringCntNext = '0;
        end else begin
          if (bus.i_btn_alarm) w_armedNext = ~r_armed;
          if (bus.i_btn_mode) begin
            w_editNext  = bus.i_cur_time;
            w_stateNext = SET_TH;
          end
        end
      end
      SET_TH, SET_AH: begin
        if (bus.i_btn_mode)
          w_stateNext = (r_state == SET_TH) ? SET_TM : SET_AM;
        else if (bus.i_btn_inc)
          w_editNext = {incHour(r_edit[15:8]), r_edit[7:0]};
      end
      SET_TM: begin
        if (bus.i_btn_mode) begin
          w_stateNext  = SET_AH;
          w_ldNext     = 1'b1;
          w_ldTimeNext = r_edit;
          w_editNext   = r_alarm;
        end else if (bus.i_btn_inc) begin
          w_editNext = {r_edit[15:8], incMin(r_edit[7:0])};
        end
      end
      SET_AM: begin
        if (bus.i_btn_mode) begin
          w_stateNext = RUN;
          w_alarmNext = r_edit;
        end else if (bus.i_btn_inc) begin
          w_editNext = {r_edit[15:8], incMin(r_edit[7:0])};
        end
      end
      RING: begin
        if (bus.i_btn_alarm || bus.i_btn_mode) begin
          w_stateNext = RUN;
        end else if (bus.i_tick) begin
          if (r_ringCnt == RW'(RING_TICKS - 1)) w_stateNext = RUN;
          else                                  w_ringCntNext = r_ringCnt + RW'(1);
        end
      end
      default: w_stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edit    <= 16'h1200;
      r_alarm   <= 16'h0600;
      r_ldTime  <= 16'h1200;
      r_armed   <= 1'b0;
      r_ld      <= 1'b0;
      r_matchQ  <= 1'b0;
      r_ringCnt <= '0;
    end else begin
      r_edit    <= w_editNext;
      r_alarm   <= w_alarmNext;
      r_ldTime  <= w_ldTimeNext;
      r_armed   <= w_armedNext;
      r_ld      <= w_ldNext;
      r_matchQ  <= w_match;
      r_ringCnt <= w_ringCntNext;
    end
  end

  // Blink restarts dark-free on every mode step so the new field is visible at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_enterSet) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_inSet) begin
      if (r_blinkCnt == BW'(BLINK_CYCLES - 1)) begin
        r_blinkCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_blinkCnt <= r_blinkCnt + BW'(1);
      end
    end
  end

  assign bus.o_cnt_en      = w_runLike;
  assign bus.o_ring        = (r_state == RING);
  assign bus.o_alarm_armed = r_armed;
  assign bus.o_ld          = r_ld;
  assign bus.o_ld_time     = r_ldTime;
  assign bus.o_disp_time   = w_runLike ? bus.i_cur_time : r_edit;
  assign bus.o_blank       = !(w_inSet && r_phase) ? 4'b0000 :
                             (w_hourState ? 4'b1100 : 4'b0011);

endmodule

// File: tb/tb_clock_ctrl.sv
// Vector-table bench for clock_ctrl: each record drives one cycle and queues the
// outputs expected after that edge; a checker pops and compares them.
module tb_clock_ctrl;

  logic clk;
  logic rst_n;

  clock_ctrl_if bus ();

  clock_ctrl #(.BLINK_CYCLES(4), .RING_TICKS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        tick, mode, inc, alarm;
    logic [15:0] cur;
    logic        cntEn, ld;
    logic [15:0] ldTime, disp;
    logic [3:0]  blank;
    logic        armed, ring;
  } vec_t;

  vec_t vecs[44];
  vec_t expQ[$];
  int   applied = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic t, m, i, a, input logic [15:0] cur,
                              input logic en, ld, input logic [15:0] ldt, disp,
                              input logic [3:0] blank, input logic arm, ring);
    vec_t v;
    v.tick = t; v.mode = m; v.inc = i; v.alarm = a; v.cur = cur;
    v.cntEn = en; v.ld = ld; v.ldTime = ldt; v.disp = disp;
    v.blank = blank; v.armed = arm; v.ring = ring;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.i_tick      = v.tick;
    bus.i_btn_mode  = v.mode;
    bus.i_btn_inc   = v.inc;
    bus.i_btn_alarm = v.alarm;
    bus.i_cur_time  = v.cur;
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input bit waitEdge, input string name);
    vec_t e;
    logic [39:0] got, req;
    if (waitEdge) @(posedge clk);
    #1;
    applied++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: no expected record queued", name);
    end else begin
      e   = expQ.pop_front();
      got = {bus.o_cnt_en, bus.o_ld, bus.o_ld_time, bus.o_disp_time, bus.o_blank,
             bus.o_alarm_armed, bus.o_ring};
      req = {e.cntEn, e.ld, e.ldTime, e.disp, e.blank, e.armed, e.ring};
      if (got !== req) begin
        miscompares++;
        $display("[TB] FAIL %s: {en,ld,ld_time,disp,blank,armed,ring} got %h required %h",
                 name, got, req);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_tick = 1'b0; bus.i_btn_mode = 1'b0; bus.i_btn_inc = 1'b0;
    bus.i_btn_alarm = 1'b0; bus.i_cur_time = 16'h1200;

    //                t  m  i  a  cur        en ld ld_time   disp      blank    ar ring
    vecs[0]  = mk(0, 1, 0, 0, 16'h1200, 0, 0, 16'h1200, 16'h1200, 4'b0000, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 16'h1200, 0, 0, 16'h1200, 16'h1200, 4'b0000, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 16'h1200, 0, 0, 16'h1200, 16'h1201, 4'b0000, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 16'h1200, 0, 0, 16'h1200, 16'h1202, 4'b0000, 0, 0);
    vecs[4]  = mk(0, 0, 1, 0, 16'h1200, 0, 0, 16'h1200, 16'h1203, 4'b0000, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 16'h1200, 0, 1, 16'h1203, 16'h0600, 4'b0000, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 16'h1200, 0, 0, 16'h1203, 16'h0600, 4'b0000, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 16'h1200, 0, 0, 16'h1203, 16'h0700, 4'b0000, 0, 0);
    vecs[8]  = mk(0, 1, 1, 0, 16'h1200, 0, 0, 16'h1203, 16'h0700, 4'b0000, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 16'h1200, 0, 0, 16'h1203, 16'h0700, 4'b0000, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 16'h1200, 0, 0, 16'h1203, 16'h0701, 4'b0000, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 16'h1200, 1, 0, 16'h1203, 16'h1200, 4'b0000, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 16'h1200, 1, 0, 16'h1203, 16'h1200, 4'b0000, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 16'h0700, 1, 0, 16'h1203, 16'h0700, 4'b0000, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 1);
    vecs[15] = mk(1, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 1);
    vecs[16] = mk(1, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 1);
    vecs[17] = mk(1, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 0);
    vecs[18] = mk(0, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 0);
    vecs[19] = mk(0, 0, 0, 0, 16'h0702, 1, 0, 16'h1203, 16'h0702, 4'b0000, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 1);
    vecs[21] = mk(0, 0, 0, 1, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 0);
    vecs[23] = mk(0, 0, 0, 0, 16'h0702, 1, 0, 16'h1203, 16'h0702, 4'b0000, 1, 0);
    vecs[24] = mk(0, 1, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 1);
    vecs[25] = mk(0, 1, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 1, 0);
    vecs[26] = mk(0, 0, 0, 1, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 0, 0);
    vecs[27] = mk(0, 0, 0, 0, 16'h0702, 1, 0, 16'h1203, 16'h0702, 4'b0000, 0, 0);
    vecs[28] = mk(0, 0, 0, 0, 16'h0701, 1, 0, 16'h1203, 16'h0701, 4'b0000, 0, 0);
    vecs[29] = mk(0, 1, 0, 0, 16'h1259, 0, 0, 16'h1203, 16'h1259, 4'b0000, 0, 0);
    vecs[30] = mk(0, 0, 1, 0, 16'h1259, 0, 0, 16'h1203, 16'h0159, 4'b0000, 0, 0);
    vecs[31] = mk(0, 1, 1, 0, 16'h1259, 0, 0, 16'h1203, 16'h0159, 4'b0000, 0, 0);
    vecs[32] = mk(0, 0, 1, 0, 16'h1259, 0, 0, 16'h1203, 16'h0100, 4'b0000, 0, 0);
    vecs[33] = mk(0, 1, 0, 0, 16'h1259, 0, 1, 16'h0100, 16'h0701, 4'b0000, 0, 0);
    vecs[34] = mk(0, 1, 0, 0, 16'h1259, 0, 0, 16'h0100, 16'h0701, 4'b0000, 0, 0);
    vecs[35] = mk(0, 1, 0, 0, 16'h1259, 1, 0, 16'h0100, 16'h1259, 4'b0000, 0, 0);
    vecs[36] = mk(0, 1, 0, 0, 16'h0900, 0, 0, 16'h0100, 16'h0900, 4'b0000, 0, 0);
    vecs[37] = mk(0, 0, 1, 0, 16'h0900, 0, 0, 16'h0100, 16'h1000, 4'b0000, 0, 0);
    vecs[38] = mk(0, 0, 1, 0, 16'h0900, 0, 0, 16'h0100, 16'h1100, 4'b0000, 0, 0);
    vecs[39] = mk(0, 0, 1, 0, 16'h0900, 0, 0, 16'h0100, 16'h1200, 4'b0000, 0, 0);
    vecs[40] = mk(0, 0, 1, 0, 16'h0900, 0, 0, 16'h0100, 16'h0100, 4'b1100, 0, 0);
    vecs[41] = mk(0, 1, 0, 0, 16'h0900, 0, 0, 16'h0100, 16'h0100, 4'b0000, 0, 0);
    vecs[42] = mk(0, 1, 0, 0, 16'h0900, 0, 1, 16'h0100, 16'h0701, 4'b0000, 0, 0);
    vecs[43] = mk(0, 1, 0, 0, 16'h0900, 0, 0, 16'h0100, 16'h0701, 4'b0000, 0, 0);

    #12;
    expQ.push_back(mk(0, 0, 0, 0, 16'h1200, 1, 0, 16'h1200, 16'h1200, 4'b0000, 0, 0));
    checkOutput(0, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 44; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(1, $sformatf("vec%0d", i));
    end

    // SET_AM entered at vec43 (blink sample 1); minute digits dark every other 4 cycles.
    for (int k = 2; k <= 14; k++) begin
      applyStimulus(mk(0, 0, 0, 0, 16'h0900, 0, 0, 16'h0100, 16'h0701,
                       (((k - 1) / 4) % 2 == 1) ? 4'b0011 : 4'b0000, 0, 0));
      checkOutput(1, $sformatf("blink%0d", k));
    end

    #2 rst_n = 1'b0;
    expQ.push_back(mk(0, 0, 0, 0, 16'h0900, 1, 0, 16'h1200, 16'h0900, 4'b0000, 0, 0));
    checkOutput(0, "async_reset_set_am");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(mk(0, 1, 0, 0, 16'h0900, 0, 0, 16'h1200, 16'h0900, 4'b0000, 0, 0));
    checkOutput(1, "post_reset_set_th");
    applyStimulus(mk(0, 1, 0, 0, 16'h0900, 0, 0, 16'h1200, 16'h0900, 4'b0000, 0, 0));
    checkOutput(1, "post_reset_set_tm");
    applyStimulus(mk(0, 1, 0, 0, 16'h0900, 0, 1, 16'h0900, 16'h0600, 4'b0000, 0, 0));
    checkOutput(1, "post_reset_alarm_default");

    #2 rst_n = 1'b0;
    expQ.push_back(mk(0, 0, 0, 0, 16'h0900, 1, 0, 16'h1200, 16'h0900, 4'b0000, 0, 0));
    checkOutput(0, "reset_cancels_ld");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
